// File: rtl/ssd_axi_lite_slave_if.sv
// AXI4-Lite bus bundle for the SSD register block.
// slave modport faces the responder, master modport the bus driver.
interface ssd_axi_lite_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/ssd_axi_lite_slave.sv
// AXI4-Lite responder with 4 regs driving a muxed 4-digit SSD.
// Ports: ACLK/ARESET, s_axi (slave), SSD_AN/SSD_SEG/SSD_DP (active-low).
module ssd_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SCAN_DIV_RST       = 100000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  ssd_axi_lite_slave_if.slave  s_axi,
  output logic [3:0]           SSD_AN,
  output logic [6:0]           SSD_SEG,
  output logic                 SSD_DP
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t       r_wstate, w_wstate_nx;
  rstate_t       r_rstate, w_rstate_nx;
  logic          r_aw_done, r_w_done;
  logic [1:0]    r_aw_idx;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [DW-1:0] r_regs [4];
  logic [DW-1:0] r_rdata;
  logic [31:0]   r_cnt;
  logic [1:0]    r_idx;
  logic          w_awready, w_wready, w_arready, w_commit;
  logic          w_en;
  logic [31:0]   w_div;
  logic [3:0]    w_nib;
  logic [3:0]    w_dp_sel;
  logic [6:0]    w_seg;
  logic          w_unused;

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[AW-3:0],
                      s_axi.S_AXI_ARADDR[AW-3:0]};

  // Write channel FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nx;
  end

  always_comb begin
    w_wstate_nx = r_wstate;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready = ~r_aw_done;
        w_wready  = ~r_w_done;
        if (r_aw_done && r_w_done) begin
          w_commit    = 1'b1;
          w_wstate_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) w_wstate_nx = W_IDLE;
      end
    endcase
  end

  // READY is masked during reset so nothing handshakes mid-reset
  assign s_axi.S_AXI_AWREADY = w_awready & ~ARESET;
  assign s_axi.S_AXI_WREADY  = w_wready & ~ARESET;
  assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
  assign s_axi.S_AXI_BRESP   = 2'b00;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (s_axi.S_AXI_AWVALID && w_awready) begin
        r_aw_done <= 1'b1;
        r_aw_idx  <= s_axi.S_AXI_AWADDR[AW-1 -: 2];
      end
      if (s_axi.S_AXI_WVALID && w_wready) begin
        r_w_done <= 1'b1;
        r_wdata  <= s_axi.S_AXI_WDATA;
        r_wstrb  <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_regs[0] <= '0;
      r_regs[1] <= '0;
      r_regs[2] <= DW'(SCAN_DIV_RST);
      r_regs[3] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < SW; b++) begin
        if (r_wstrb[b])
          r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // Read channel FSM; nonblocking sample gives pre-write data
  always_ff @(posedge ACLK) begin
    if (ARESET) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nx;
  end

  always_comb begin
    w_rstate_nx = r_rstate;
    w_arready   = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.S_AXI_ARVALID) w_rstate_nx = R_DATA;
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) w_rstate_nx = R_IDLE;
      end
    endcase
  end

  assign s_axi.S_AXI_ARREADY = w_arready & ~ARESET;
  assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RDATA   = r_rdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_rdata <= '0;
    else if (w_arready && s_axi.S_AXI_ARVALID)
      r_rdata <= r_regs[s_axi.S_AXI_ARADDR[AW-1 -: 2]];
  end

  // Digit scan
  assign w_en     = r_regs[1][0];
  assign w_div    = (r_regs[2][31:0] == 32'd0) ? 32'd1 : r_regs[2][31:0];
  assign w_nib    = r_regs[0][{r_idx, 2'b00} +: 4];
  assign w_dp_sel = r_regs[1][7:4];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_en) begin
      if (r_cnt >= w_div) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_seg = 7'h7F;
    unique case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || !w_en) begin
      SSD_AN  <= 4'hF;
      SSD_SEG <= 7'h7F;
      SSD_DP  <= 1'b1;
    end else begin
      SSD_AN  <= ~(4'b0001 << r_idx);
      SSD_SEG <= w_seg;
      SSD_DP  <= ~w_dp_sel[r_idx];
    end
  end
endmodule

// File: tb/tb_ssd_axi_lite_slave.sv
// Directed bench for ssd_axi_lite_slave.
// Drives on negedge, samples on negedge.
module tb_ssd_axi_lite_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ssd_axi_lite_slave_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  ssd_axi_lite_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .SCAN_DIV_RST(100000)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(axi),
    .SSD_AN(an),
    .SSD_SEG(seg),
    .SSD_DP(dp)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd,
                           input int wd, input int bdly);
    bit aw_ok = 0, w_ok = 0, hs_aw, hs_w, hold_ok = 1;
    int n = 0;
    @(negedge clk);
    while (!(aw_ok && w_ok) && n < 60) begin
      if (!aw_ok && n >= awd) begin
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_AWADDR  = a;
      end
      if (!w_ok && n >= wd) begin
        axi.S_AXI_WVALID = 1'b1;
        axi.S_AXI_WDATA  = d;
        axi.S_AXI_WSTRB  = s;
      end
      hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge clk);
      n++;
      if (hs_aw) begin aw_ok = 1; axi.S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_ok = 1;  axi.S_AXI_WVALID  = 1'b0; end
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    chk("aw_w_accept", {30'd0, aw_ok, w_ok}, 32'd3);
    n = 0;
    while (!axi.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", 32'(axi.S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(axi.S_AXI_BRESP), 32'd0);
    for (int k = 0; k < bdly; k++) begin
      @(negedge clk);
      if (!axi.S_AXI_BVALID || axi.S_AXI_AWREADY || axi.S_AXI_WREADY)
        hold_ok = 0;
    end
    if (bdly > 0) chk("b_backpressure", 32'(hold_ok), 32'd1);
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    chk("b_single_a", 32'(axi.S_AXI_BVALID), 32'd0);
    @(negedge clk);
    chk("b_single_b", 32'(axi.S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          input int rdly);
    bit hs = 0, hold_ok = 1;
    int n = 0;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_ARADDR  = a;
    while (!hs && n < 20) begin
      hs = axi.S_AXI_ARREADY;
      @(negedge clk);
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    chk("ar_accept", 32'(hs), 32'd1);
    n = 0;
    while (!axi.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rvalid_seen", 32'(axi.S_AXI_RVALID), 32'd1);
    chk("rresp", 32'(axi.S_AXI_RRESP), 32'd0);
    d = axi.S_AXI_RDATA;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      if (!axi.S_AXI_RVALID || axi.S_AXI_ARREADY ||
          axi.S_AXI_RDATA !== d)
        hold_ok = 0;
    end
    if (rdly > 0) chk("r_backpressure", 32'(hold_ok), 32'd1);
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    chk("r_done", 32'(axi.S_AXI_RVALID), 32'd0);
  endtask

  logic [31:0] rd;
  logic [3:0]  exp_an  [4];
  logic [6:0]  exp_seg [4];
  logic        exp_dp  [4];

  initial begin
    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{4'h3, 32'hDEAD_BEEF, 4'b0101, 32'h00AD_00EF};
    vecs[5] = '{4'hE, 32'hFFFF_FFFF, 4'b1000, 32'hFF00_0004};
    vecs[6] = '{4'h9, 32'h1234_5678, 4'b0000, 32'h0000_0003};
    vecs[7] = '{4'h5, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{7'h40, 7'h79, 7'h00, 7'h0E};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};

    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(axi.S_AXI_WREADY), 32'd0);
    chk("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    chk("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    axi_read(4'h8, rd, 0);
    chk("rst_reg2", rd, 32'h0001_86A0);

    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0);
      axi_read(vecs[i].addr, rd, 0);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end
    axi_read(4'h0, rd, 0); chk("final_reg0", rd, 32'h00AD_00EF);
    axi_read(4'h4, rd, 0); chk("final_reg1", rd, 32'hA5A5_A5A5);
    axi_read(4'h8, rd, 0); chk("final_reg2", rd, 32'h0000_0003);
    axi_read(4'hC, rd, 0); chk("final_reg3", rd, 32'hFF00_0004);

    axi_write(4'hC, 32'h0, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, 3, 0, 0);
    axi_read(4'hC, rd, 0);
    chk("w_before_aw", rd, 32'h0000_CC00);
    axi_write(4'hC, 32'h1122_3344, 4'b0001, 0, 3, 0);
    axi_read(4'hC, rd, 0);
    chk("aw_before_w", rd, 32'h0000_CC44);

    axi_write(4'h8, 32'h0000_0055, 4'hF, 0, 0, 10);
    axi_read(4'h8, rd, 10);
    chk("bp_reg2", rd, 32'h0000_0055);

    axi_write(4'h0, 32'h0000_F810, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h0000_0004, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h0000_0021, 4'hF, 0, 0, 0);
    begin
      bit found = 0;
      logic [3:0] prev;
      for (int n = 0; n < 40 && !found; n++) begin
        prev = an;
        @(negedge clk);
        if (an == 4'hE && prev != 4'hE) found = 1;
      end
      chk("scan_sync", 32'(found), 32'd1);
      chk("scan0_seg", 32'(seg), 32'(exp_seg[0]));
      chk("scan0_dp", 32'(dp), 32'(exp_dp[0]));
      for (int j = 1; j <= 4; j++) begin
        repeat (4) @(negedge clk);
        chk($sformatf("scan%0d_hold", j), 32'(an),
            32'(exp_an[(j-1)%4]));
        @(negedge clk);
        chk($sformatf("scan%0d_an", j), 32'(an), 32'(exp_an[j%4]));
        chk($sformatf("scan%0d_seg", j), 32'(seg), 32'(exp_seg[j%4]));
        chk($sformatf("scan%0d_dp", j), 32'(dp), 32'(exp_dp[j%4]));
      end
    end
    axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0);
    chk("blank_an", 32'(an), 32'hF);
    chk("blank_seg", 32'(seg), 32'h7F);
    chk("blank_dp", 32'(dp), 32'd1);

    begin
      bit hs = 0, bseen = 0;
      int n = 0;
      @(negedge clk);
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_AWADDR  = 4'h0;
      while (!hs && n < 20) begin
        hs = axi.S_AXI_AWREADY;
        @(negedge clk);
        n++;
      end
      axi.S_AXI_AWVALID = 1'b0;
      chk("midrst_aw", 32'(hs), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (axi.S_AXI_BVALID) bseen = 1;
      end
      chk("midrst_no_b", 32'(bseen), 32'd0);
      chk("midrst_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
      axi_read(4'h0, rd, 0);
      chk("midrst_reg0", rd, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
